// File: rtl/decoder_scan_ctrl.sv
// Scan controller that walks a 2-to-4 decoder across the enabled channels of a
// captured mask, with per-channel dwell and a one-cycle break-before-make gap.
module decoder_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_GAP    = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [3:0]           mask_q, mask_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           sel_q, sel_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [1:0]           first_ch_s;
    logic [1:0]           next_ch_s;
    logic                 wrap_s;
    logic                 start_ok_s;
    logic                 dwell_end_s;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] r;
        casez (m)
            4'b???1: r = 2'd0;
            4'b??10: r = 2'd1;
            4'b?100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Next enabled channel in ascending cyclic order; offset 4 lands back on cur.
    function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end else begin
                r     = r;
                found = found;
            end
        end
        return r;
    endfunction

    // Channel selection helpers shared by the state machine.
    always_comb begin
        first_ch_s  = lowest_set(mask);
        next_ch_s   = next_set(mask_q, sel_q);
        wrap_s      = (next_ch_s <= sel_q);
        start_ok_s  = start && !stop && (mask != 4'b0000);
        dwell_end_s = (cnt_q == dwell_q);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    mode_d  = mode;
                    mask_d  = mask;
                    dwell_d = dwell;
                    cnt_d   = {DWELL_W{1'b0}};
                    sel_d   = first_ch_s;
                    state_d = ST_ACTIVE;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!dwell_end_s) begin
                    cnt_d  = cnt_q + DWELL_W'(1);
                    en_d   = 1'b1;
                    busy_d = 1'b1;
                end else if (!mode_q && wrap_s) begin
                    // Last channel of a single sweep: no trailing gap.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_GAP;
                    sel_d   = next_ch_s;
                    busy_d  = 1'b1;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                    cnt_d   = {DWELL_W{1'b0}};
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            mask_q  <= 4'b0000;
            dwell_q <= {DWELL_W{1'b0}};
            cnt_q   <= {DWELL_W{1'b0}};
            sel_q   <= 2'b00;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel  = sel_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// Output-relationship checker for decoder_scan_ctrl.
module decoder_scan_ctrl_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       en,
    input logic       busy,
    input logic       done
);

    // The decoder must never be enabled outside a scan, and done only in IDLE.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(en && !busy)) else $error("chk: en high while not busy");
            assert (!(done && busy)) else $error("chk: done high while busy");
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl with hand-computed output vectors.
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [3:0] mask;
    logic [7:0] dwell;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fails;

    decoder_scan_ctrl #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .mask  (mask),
        .dwell (dwell),
        .sel   (sel),
        .en    (en),
        .busy  (busy),
        .done  (done)
    );

    decoder_scan_ctrl_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] s, input logic e,
                              input logic b, input logic d);
        n_checks++;
        assert ({sel, en, busy, done} === {s, e, b, d})
        else begin
            n_fails++;
            $error("FAIL %s observed sel=%0d en=%b busy=%b done=%b expected sel=%0d en=%b busy=%b done=%b",
                   tag, sel, en, busy, done, s, e, b, d);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        start = 1'b1;
        stop  = 1'b0;
        mode  = 1'b0;
        mask  = 4'b1111;
        dwell = 8'd2;

        // Reset with start held.
        tick();
        expect_out("reset_c1", 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("reset_c2", 2'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        expect_out("reset_idle", 2'd0, 1'b0, 1'b0, 1'b0);

        // Single sweep, all channels, dwell=2; inputs changed after capture.
        start = 1'b1;
        tick();
        start = 1'b0;
        mask  = 4'b0000;
        dwell = 8'd7;
        mode  = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            for (int c = 0; c < 3; c++) begin
                if (ch == 1 && c == 1) start = 1'b1;
                else start = 1'b0;
                expect_out($sformatf("sweep_ch%0d_act%0d", ch, c), 2'(ch), 1'b1, 1'b1, 1'b0);
                tick();
            end
            start = 1'b0;
            if (ch < 3) begin
                expect_out($sformatf("sweep_gap%0d", ch), 2'(ch + 1), 1'b0, 1'b1, 1'b0);
                tick();
            end
        end
        expect_out("sweep_done", 2'd3, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("sweep_after_done", 2'd3, 1'b0, 1'b0, 1'b0);

        // Ignored starts: empty mask, then start together with stop.
        mode  = 1'b0;
        mask  = 4'b0000;
        start = 1'b1;
        tick();
        expect_out("start_mask0", 2'd3, 1'b0, 1'b0, 1'b0);
        mask = 4'b1111;
        stop = 1'b1;
        tick();
        expect_out("start_with_stop", 2'd3, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        stop  = 1'b0;

        // Sparse mask 1010 with dwell=0.
        mask  = 4'b1010;
        dwell = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("sparse_ch1", 2'd1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("sparse_gap", 2'd3, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("sparse_ch3", 2'd3, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("sparse_done", 2'd3, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("sparse_idle", 2'd3, 1'b0, 1'b0, 1'b0);

        // Maximum dwell: 256 cycles on channel 2.
        mask  = 4'b0100;
        dwell = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 256; c++) begin
            if (c == 0 || c == 255) expect_out($sformatf("maxdwell_%0d", c), 2'd2, 1'b1, 1'b1, 1'b0);
            else if (!(en && busy)) expect_out("maxdwell_mid", 2'd2, 1'b1, 1'b1, 1'b0);
            tick();
        end
        expect_out("maxdwell_done", 2'd2, 1'b0, 1'b0, 1'b1);
        tick();

        // Continuous single channel, dwell=1, then stop mid-ACTIVE.
        mode  = 1'b1;
        mask  = 4'b0001;
        dwell = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            expect_out($sformatf("cont_r%0d_a", r), 2'd0, 1'b1, 1'b1, 1'b0);
            tick();
            expect_out($sformatf("cont_r%0d_b", r), 2'd0, 1'b1, 1'b1, 1'b0);
            tick();
            expect_out($sformatf("cont_r%0d_gap", r), 2'd0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        expect_out("cont_before_stop", 2'd0, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        expect_out("cont_stopped", 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("cont_no_done", 2'd0, 1'b0, 1'b0, 1'b0);

        // Continuous two channels, reset mid-ACTIVE on channel 1.
        mask  = 4'b0011;
        dwell = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("cont2_ch0", 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("cont2_gap1", 2'd1, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("cont2_ch1", 2'd1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("cont2_wrap_gap", 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("cont2_ch0_again", 2'd0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("cont2_gap1_again", 2'd1, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("cont2_ch1_again", 2'd1, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        expect_out("cont2_reset", 2'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_out("cont2_post_reset", 2'd0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
